// File: rtl/bp_dram_channel_responder.sv
// DRAM-side responder for the BedRock burst-to-DRAM bridge: a word array with masked
// writes and fixed-latency, in-order, credit-limited read responses.
module bp_dram_channel_responder #(
  parameter int unsigned channel_addr_width_p = 32,
  parameter int unsigned data_width_p         = 64,
  parameter int unsigned mem_els_p            = 1024,
  parameter int unsigned read_latency_p       = 4,
  parameter int unsigned resp_fifo_els_p      = 8
) (
  input  logic                            clk_i,
  input  logic                            reset_i,

  input  logic [channel_addr_width_p-1:0] dram_ch_addr_i,
  input  logic                            dram_write_not_read_i,
  input  logic                            dram_v_i,
  output logic                            dram_yumi_o,

  input  logic [data_width_p-1:0]         dram_data_i,
  input  logic [data_width_p/8-1:0]       dram_mask_i,
  input  logic                            dram_data_v_i,
  output logic                            dram_data_yumi_o,

  output logic [data_width_p-1:0]         dram_data_o,
  output logic [channel_addr_width_p-1:0] dram_ch_addr_o,
  output logic                            dram_data_v_o,
  input  logic                            dram_data_ready_i
);

  localparam int unsigned byte_num_lp  = data_width_p / 8;
  localparam int unsigned offset_w_lp  = $clog2(byte_num_lp);
  localparam int unsigned idx_w_lp     = $clog2(mem_els_p);
  localparam int unsigned credit_w_lp  = $clog2(resp_fifo_els_p + 1);
  localparam int unsigned ptr_w_lp     = (resp_fifo_els_p > 1) ? $clog2(resp_fifo_els_p) : 1;

  typedef struct packed {
    logic [channel_addr_width_p-1:0] addr;
    logic [data_width_p-1:0]         data;
  } resp_s;

  logic [idx_w_lp-1:0]     word_idx;
  logic [data_width_p-1:0] rd_word;
  logic                    credit_avail;
  logic                    write_accept;
  logic                    read_accept;
  logic                    enq;
  logic                    deq;
  resp_s                   rd_entry;

  logic [credit_w_lp-1:0]  credit_r;
  logic [data_width_p-1:0] mem_r [mem_els_p];

  logic [read_latency_p-1:0] pipe_v_r;
  resp_s                     pipe_r [read_latency_p];

  resp_s                   fifo_r [resp_fifo_els_p];
  logic [ptr_w_lp-1:0]     wr_ptr_r;
  logic [ptr_w_lp-1:0]     rd_ptr_r;
  logic [credit_w_lp-1:0]  count_r;
  resp_s                   head;

  // Byte offset bits are dropped; upper index bits wrap silently.
  assign word_idx = dram_ch_addr_i[offset_w_lp +: idx_w_lp];
  assign rd_word  = mem_r[word_idx];
  assign rd_entry = '{addr: dram_ch_addr_i, data: rd_word};

  // Accept decisions depend only on request valids and registered state.
  assign credit_avail = (credit_r < credit_w_lp'(resp_fifo_els_p));
  assign write_accept = ~reset_i & dram_v_i & dram_write_not_read_i & dram_data_v_i;
  assign read_accept  = ~reset_i & dram_v_i & ~dram_write_not_read_i & credit_avail;

  assign dram_yumi_o      = write_accept | read_accept;
  assign dram_data_yumi_o = write_accept;

  // Byte-masked array write; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (write_accept) begin
      for (int unsigned b = 0; b < byte_num_lp; b++) begin
        if (dram_mask_i[b]) begin
          mem_r[word_idx][b*8 +: 8] <= dram_data_i[b*8 +: 8];
        end
      end
    end
  end

  // Non-stalling read pipeline valid tags.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pipe_v_r <= '0;
    end else begin
      pipe_v_r[0] <= read_accept;
      for (int unsigned i = 1; i < read_latency_p; i++) begin
        pipe_v_r[i] <= pipe_v_r[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    pipe_r[0] <= rd_entry;
    for (int unsigned i = 1; i < read_latency_p; i++) begin
      pipe_r[i] <= pipe_r[i-1];
    end
  end

  // Pipeline output always lands in the FIFO; credits guarantee a free slot.
  assign enq = pipe_v_r[read_latency_p-1];
  assign deq = dram_data_v_o & dram_data_ready_i;

  always_ff @(posedge clk_i) begin
    if (enq) begin
      fifo_r[wr_ptr_r] <= pipe_r[read_latency_p-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (enq) begin
        wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(resp_fifo_els_p - 1)) ? '0 : wr_ptr_r + ptr_w_lp'(1);
      end
      if (deq) begin
        rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(resp_fifo_els_p - 1)) ? '0 : rd_ptr_r + ptr_w_lp'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= '0;
    end else begin
      case ({enq, deq})
        2'b10:   count_r <= count_r + credit_w_lp'(1);
        2'b01:   count_r <= count_r - credit_w_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Credits cover reads in the pipeline plus entries waiting in the FIFO.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      credit_r <= '0;
    end else begin
      case ({read_accept, deq})
        2'b10:   credit_r <= credit_r + credit_w_lp'(1);
        2'b01:   credit_r <= credit_r - credit_w_lp'(1);
        default: credit_r <= credit_r;
      endcase
    end
  end

  assign head           = fifo_r[rd_ptr_r];
  assign dram_data_v_o  = (count_r != '0);
  assign dram_data_o    = head.data;
  assign dram_ch_addr_o = head.addr;

endmodule

// File: tb/tb_bp_dram_channel_responder.sv
// Directed bench for bp_dram_channel_responder: a queue-based reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_bp_dram_channel_responder;

  localparam int L    = 4;
  localparam int DEPTH = 8;
  localparam int ELS  = 1024;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] dram_ch_addr_i;
  logic        dram_write_not_read_i;
  logic        dram_v_i;
  logic        dram_yumi_o;
  logic [63:0] dram_data_i;
  logic [7:0]  dram_mask_i;
  logic        dram_data_v_i;
  logic        dram_data_yumi_o;
  logic [63:0] dram_data_o;
  logic [31:0] dram_ch_addr_o;
  logic        dram_data_v_o;
  logic        dram_data_ready_i;

  bp_dram_channel_responder dut (
    .clk_i                (clk_i),
    .reset_i              (reset_i),
    .dram_ch_addr_i       (dram_ch_addr_i),
    .dram_write_not_read_i(dram_write_not_read_i),
    .dram_v_i             (dram_v_i),
    .dram_yumi_o          (dram_yumi_o),
    .dram_data_i          (dram_data_i),
    .dram_mask_i          (dram_mask_i),
    .dram_data_v_i        (dram_data_v_i),
    .dram_data_yumi_o     (dram_data_yumi_o),
    .dram_data_o          (dram_data_o),
    .dram_ch_addr_o       (dram_ch_addr_o),
    .dram_data_v_o        (dram_data_v_o),
    .dram_data_ready_i    (dram_data_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  known;
    logic [31:0] addr;
    int          arrive;
  } exp_t;

  exp_t        q[$];
  logic [63:0] mdata  [ELS];
  logic [7:0]  mknown [ELS];

  task automatic check1(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  function automatic logic [63:0] bmask(input logic [7:0] k);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 3) & 32'(ELS - 1));
  endfunction

  // Reference model: responses become visible L edges after accept, leave in order,
  // and the number outstanding never exceeds DEPTH.
  always @(negedge clk_i) begin
    logic e_v, e_yw, e_yr;
    exp_t e;
    cyc++;
    e_v  = (q.size() > 0) && (q[0].arrive <= cyc);
    e_yw = !reset_i && dram_v_i && dram_write_not_read_i && dram_data_v_i;
    e_yr = !reset_i && dram_v_i && !dram_write_not_read_i && (q.size() < DEPTH);
    check1("yumi", 64'(dram_yumi_o), 64'(e_yw | e_yr));
    check1("data_yumi", 64'(dram_data_yumi_o), 64'(e_yw));
    check1("resp_v", 64'(dram_data_v_o), 64'(e_v));
    if (e_v && dram_data_v_o) begin
      check1("resp_addr", 64'(dram_ch_addr_o), 64'(q[0].addr));
      check1("resp_data", dram_data_o & bmask(q[0].known), q[0].data & bmask(q[0].known));
    end
    if (reset_i) begin
      q.delete();
    end else begin
      if (e_v && dram_data_ready_i) void'(q.pop_front());
      if (e_yr) begin
        e.data   = mdata[widx(dram_ch_addr_i)];
        e.known  = mknown[widx(dram_ch_addr_i)];
        e.addr   = dram_ch_addr_i;
        e.arrive = cyc + 1 + L;
        q.push_back(e);
      end
      if (e_yw) begin
        for (int b = 0; b < 8; b++) begin
          if (dram_mask_i[b]) begin
            mdata[widx(dram_ch_addr_i)][b*8 +: 8] = dram_data_i[b*8 +: 8];
            mknown[widx(dram_ch_addr_i)][b]       = 1'b1;
          end
        end
      end
    end
  end

  // Present a request (entered/left at posedge+1); ok=0 on timeout, dy=data_yumi at accept.
  task automatic req(input logic wnr, input logic [31:0] a, output bit ok, output logic dy);
    ok = 0;
    dy = 1'b0;
    dram_v_i = 1'b1;
    dram_write_not_read_i = wnr;
    dram_ch_addr_i = a;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (dram_yumi_o) begin
        ok = 1;
        dy = dram_data_yumi_o;
        break;
      end
    end
    if (!ok) check1("req_timeout", 64'(0), 64'(1));
    @(posedge clk_i); #1;
    dram_v_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
    bit ok; logic dy;
    dram_data_i = d;
    dram_mask_i = m;
    dram_data_v_i = 1'b1;
    req(1'b1, a, ok, dy);
    dram_data_v_i = 1'b0;
  endtask

  // Read and compare against a literal value, including the accept-to-valid latency.
  task automatic rd_lit(input string name, input logic [31:0] a, input logic [63:0] d);
    bit ok; logic dy; int lat;
    req(1'b0, a, ok, dy);
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (dram_data_v_o) break;
      @(posedge clk_i);
      lat++;
    end
    check1({name, "_lat"}, 64'(lat), 64'(L));
    check1({name, "_data"}, dram_data_o, d);
    check1({name, "_addr"}, 64'(dram_ch_addr_o), 64'(a));
    @(posedge clk_i); #1;
  endtask

  initial begin
    bit ok; logic dy; int k, nv, ny; logic acc;
    for (int i = 0; i < ELS; i++) begin
      mknown[i] = '0;
      mdata[i]  = '0;
    end
    reset_i = 1'b1;
    dram_ch_addr_i = '0; dram_write_not_read_i = 1'b0; dram_v_i = 1'b1;
    dram_data_i = '0; dram_mask_i = '0; dram_data_v_i = 1'b1; dram_data_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check1("reset_yumi", 64'(dram_yumi_o), 64'(0));
    check1("reset_data_yumi", 64'(dram_data_yumi_o), 64'(0));
    check1("reset_resp_v", 64'(dram_data_v_o), 64'(0));
    @(posedge clk_i); #1;
    reset_i = 1'b0; dram_v_i = 1'b0; dram_data_v_i = 1'b0;
    @(posedge clk_i); #1;

    // Full write then read-after-write on the next cycle.
    wr(32'h40, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    rd_lit("raw", 32'h40, 64'hDEADBEEF_CAFEF00D);

    // Partial mask touches only the low four bytes.
    wr(32'h80, 64'h1111_1111_1111_1111, 8'hFF);
    wr(32'h80, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    rd_lit("mask", 32'h80, 64'h1111_1111_AAAA_AAAA);

    // Aliasing addresses share a word; echoed address stays unmodified.
    wr(32'h40 + 32'(8 * ELS), 64'h0123_4567_89AB_CDEF, 8'hFF);
    rd_lit("wrap_lo", 32'h40, 64'h0123_4567_89AB_CDEF);
    wr(32'h40, 64'hFEDC_BA98_7654_3210, 8'hFF);
    rd_lit("wrap_hi", 32'h40 + 32'(8 * ELS), 64'hFEDC_BA98_7654_3210);
    wr(32'h43, 64'h5555_6666_7777_8888, 8'hFF);
    rd_lit("offset", 32'h45, 64'h5555_6666_7777_8888);

    // Back-to-back reads against a stalled consumer.
    for (int i = 0; i < 20; i++) wr(32'h100 + 32'(8 * i), {32'hC0DE0000 + 32'(i), 32'(i)}, 8'hFF);
    dram_data_ready_i = 1'b0;
    k = 0;
    dram_v_i = 1'b1; dram_write_not_read_i = 1'b0; dram_ch_addr_i = 32'h100;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i); acc = dram_yumi_o;
      @(posedge clk_i); #1;
      if (acc) begin k++; dram_ch_addr_i = 32'h100 + 32'(8 * k); end
    end
    check1("stall_accepts", 64'(k), 64'(DEPTH));
    dram_data_ready_i = 1'b1;
    for (int c = 0; c < 200 && k < 20; c++) begin
      @(negedge clk_i); acc = dram_yumi_o;
      @(posedge clk_i); #1;
      if (acc) begin
        k++;
        if (k < 20) dram_ch_addr_i = 32'h100 + 32'(8 * k); else dram_v_i = 1'b0;
      end
    end
    dram_v_i = 1'b0;
    check1("all_accepts", 64'(k), 64'(20));
    repeat (30) @(posedge clk_i);
    @(negedge clk_i);
    check1("drained", 64'(dram_data_v_o), 64'(0));
    @(posedge clk_i); #1;

    // Pending write data is not consumed by a read.
    dram_data_i = 64'h0BAD_F00D_0BAD_F00D; dram_mask_i = 8'hFF; dram_data_v_i = 1'b1;
    req(1'b0, 32'h200, ok, dy);
    check1("read_no_data_yumi", 64'(dy), 64'(0));
    @(negedge clk_i);
    check1("idle_data_yumi", 64'(dram_data_yumi_o), 64'(0));
    @(posedge clk_i); #1;
    req(1'b1, 32'h200, ok, dy);
    check1("write_data_yumi", 64'(dy), 64'(1));
    dram_data_v_i = 1'b0;
    repeat (8) @(posedge clk_i); #1;

    // Write request without data stalls.
    dram_v_i = 1'b1; dram_write_not_read_i = 1'b1; dram_ch_addr_i = 32'h208;
    ny = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i); if (dram_yumi_o) ny++;
      @(posedge clk_i); #1;
    end
    check1("no_data_stall", 64'(ny), 64'(0));
    dram_data_i = 64'h7777_0000_7777_0000; dram_mask_i = 8'hFF; dram_data_v_i = 1'b1;
    req(1'b1, 32'h208, ok, dy);
    dram_data_v_i = 1'b0;
    rd_lit("late_data", 32'h208, 64'h7777_0000_7777_0000);
    rd_lit("pending_data", 32'h200, 64'h0BAD_F00D_0BAD_F00D);

    // Reset with reads in flight discards them.
    dram_v_i = 1'b1; dram_write_not_read_i = 1'b0; dram_ch_addr_i = 32'h100;
    repeat (3) @(posedge clk_i); #1;
    dram_v_i = 1'b0;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i); if (dram_data_v_o) nv++;
    end
    check1("post_reset_resp", 64'(nv), 64'(0));
    @(posedge clk_i); #1;
    rd_lit("post_reset_read", 32'h80, 64'h1111_1111_AAAA_AAAA);

    repeat (5) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
